// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin N-way bus arbiter with a registered one-hot grant.
// Define RR_TIMEOUT_EN to enable forced preemption after MAX_HOLD grant cycles.
module rr_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 BUSY,
  output logic                 PREEMPT
);

  localparam int             IW  = $clog2(N);
  localparam logic [IW:0]    NW  = (IW+1)'(N);
  localparam logic [N-1:0]   ONE = N'(1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_d;
  logic          own_req;
  logic          release_now;
  logic          timeout;
  logic          arb;
  logic [N-1:0]  cand;
  logic [N-1:0]  rot;
  logic          win_vld;
  logic [IW-1:0] win;
  logic [IW-1:0] win_inc;
  logic [IW:0]   sum;
  logic [IW:0]   inc;
  logic [N-1:0]  gnt_d;
  logic [IW-1:0] id_d;
  logic          busy_d;
  logic          pre_d;

`ifdef RR_TIMEOUT_EN
  localparam int           HW   = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_d;
`endif

  if (N < 2 || N > 16 || MAX_HOLD < 2) begin : g_param_err
    $error("rr_bus_arbiter: illegal N or MAX_HOLD");
  end

  assign own_req     = REQ[GNT_ID];
  assign release_now = (state == OWNED) && !own_req;

`ifdef RR_TIMEOUT_EN
  assign timeout = (state == OWNED) && own_req &&
                   (hcnt == HMAX);
`else
  assign timeout = 1'b0;
`endif

  assign arb = (state == IDLE) || release_now || timeout;

  // On timeout the owner sits out this round.
  assign cand = timeout ? (REQ & ~(ONE << GNT_ID)) : REQ;

  // Rotate so bit 0 is the ptr position.
  assign rot = N'({cand, cand} >> ptr);

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    sum     = '0;
    for (int j = 0; j < N; j++) begin
      if (!win_vld && rot[j]) begin
        win_vld = 1'b1;
        sum     = {1'b0, ptr} + (IW+1)'(j);
        if (sum >= NW) sum = sum - NW;
        win     = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    inc = {1'b0, win} + (IW+1)'(1);
    if (inc == NW) inc = '0;
    win_inc = inc[IW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      GNT     <= '0;
      GNT_ID  <= '0;
      BUSY    <= 1'b0;
      PREEMPT <= 1'b0;
`ifdef RR_TIMEOUT_EN
      hcnt    <= '0;
`endif
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      GNT     <= gnt_d;
      GNT_ID  <= id_d;
      BUSY    <= busy_d;
      PREEMPT <= pre_d;
`ifdef RR_TIMEOUT_EN
      hcnt    <= hcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (win_vld) state_d = OWNED;
      OWNED:   if (release_now && !win_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = GNT;
    id_d   = GNT_ID;
    busy_d = BUSY;
    pre_d  = 1'b0;
    ptr_d  = ptr;
`ifdef RR_TIMEOUT_EN
    hcnt_d = hcnt;
`endif
    unique case (1'b1)
      (arb && win_vld): begin
        gnt_d  = ONE << win;
        id_d   = win;
        busy_d = 1'b1;
        ptr_d  = win_inc;
        pre_d  = timeout;
`ifdef RR_TIMEOUT_EN
        hcnt_d = '0;
`endif
      end
      (arb && !win_vld && !timeout): begin
        gnt_d  = '0;
        id_d   = '0;
        busy_d = 1'b0;
      end
`ifdef RR_TIMEOUT_EN
      (timeout && !win_vld): begin
        hcnt_d = '0;
      end
      default: begin
        if (hcnt != HMAX) hcnt_d = hcnt + 1'b1;
      end
`else
      default: begin
      end
`endif
    endcase
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (reset) $onehot0(GNT));

  a_busy: assert property (
    @(posedge clk) disable iff (reset) BUSY == (GNT != '0));

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: scoreboard bench for rr_bus_arbiter against a queue-level
// reference model; directed plan scenarios followed by randomized traffic.
module tb_rr_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam logic [N-1:0] ONE = N'(1);

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] REQ;
  logic [N-1:0] GNT;
  logic [1:0]   GNT_ID;
  logic         BUSY;
  logic         PREEMPT;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .REQ     (REQ),
    .GNT     (GNT),
    .GNT_ID  (GNT_ID),
    .BUSY    (BUSY),
    .PREEMPT (PREEMPT)
  );

  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    logic         busy;
    logic         pre;
  } exp_t;

  exp_t         q[$];
  logic [N-1:0] trace[$];
  logic [N-1:0] seq[$];
  logic [N-1:0] rot_exp[5];
  int           vectors     = 0;
  int           miscompares = 0;
  int           npre        = 0;
  bit           armed       = 0;
  bit           done        = 0;

  // Reference model: owner index (-1 = none), search start, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit has(input logic [N-1:0] r, input int i);
    return ((r >> i) & ONE) != '0;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int from,
                              input int skip);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (from + k) % N;
      if (c != skip && has(r, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input bit rst,
                            output exp_t e);
    int w;
    bit pre;
    pre = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0 || !has(r, m_owner)) begin
      w       = pick(r, m_ptr, -1);
      m_owner = w;
      if (w >= 0) begin
        m_ptr  = (w + 1) % N;
        m_held = 1;
      end
    end else begin
`ifdef RR_TIMEOUT_EN
      if (m_held >= MAX_HOLD) begin
        w = pick(r, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w;
          m_ptr   = (w + 1) % N;
          pre     = 1'b1;
        end
        m_held = 1;
      end else begin
        m_held++;
      end
`else
      m_held++;
`endif
    end
    e.gnt  = (m_owner >= 0) ? (ONE << m_owner) : '0;
    e.id   = m_owner;
    e.busy = (m_owner >= 0);
    e.pre  = pre;
  endtask

  task automatic apply(input logic [N-1:0] r, input bit rst);
    exp_t e;
    @(negedge clk);
    REQ = r;
    if (rst && reset == 1'b0) begin
      reset = 1'b1;
      #1;
      check("async_rst_gnt", 32'(GNT), 32'(0));
      check("async_rst_busy", 32'(BUSY), 32'(0));
    end
    reset = rst;
    model_step(r, rst, e);
    q.push_back(e);
    armed = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (q.size() == 0) begin
          if (armed) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_underflow: no expectation at %0t", $time);
          end
        end else begin
          e = q.pop_front();
          check("gnt", 32'(GNT), 32'(e.gnt));
          check("busy", 32'(BUSY), 32'(e.busy));
          check("preempt", 32'(PREEMPT), 32'(e.pre));
          if (e.busy) check("gnt_id", 32'(GNT_ID), 32'(e.id));
          check("onehot", 32'($onehot0(GNT)), 32'(1));
          trace.push_back(GNT);
          if (PREEMPT) npre++;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    int           run;
    int           bad;
    reset = 1'b1;
    REQ   = '0;
    rot_exp[0] = 4'b0001;
    rot_exp[1] = 4'b0010;
    rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000;
    rot_exp[4] = 4'b0001;

    // Reset holds grants off even with all requests high.
    repeat (3) apply('1, 1'b1);
    settle();
    check("rst_gnt", 32'(GNT), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    apply('1, 1'b0);
    settle();
    check("rst_first_gnt", 32'(GNT), 32'(4'b0001));
    check("rst_first_id", 32'(GNT_ID), 32'(0));

    // Handoff.
    apply('0, 1'b1);
    apply(4'b1010, 1'b0);
    settle();
    check("ho_gnt1", 32'(GNT), 32'(4'b0010));
    apply(4'b1000, 1'b0);
    settle();
    check("ho_gnt3", 32'(GNT), 32'(4'b1000));
    check("ho_id3", 32'(GNT_ID), 32'(3));
    apply(4'b0000, 1'b0);
    settle();
    check("ho_idle", 32'(GNT), 32'(0));
    check("ho_busy", 32'(BUSY), 32'(0));

    // Rotation: owner drops for one cycle after two grant cycles.
    apply('0, 1'b1);
    settle();
    trace.delete();
    for (int c = 0; c < 10; c++) begin
      r = '1;
      if (m_owner >= 0 && m_held == 2) r = r & ~(ONE << m_owner);
      apply(r, 1'b0);
    end
    settle();
    seq.delete();
    foreach (trace[k])
      if (trace[k] != '0 && (seq.size() == 0 || seq[$] != trace[k]))
        seq.push_back(trace[k]);
    check("rot_len", 32'(seq.size()), 32'(5));
    for (int k = 0; k < 5 && k < seq.size(); k++)
      check("rot_order", 32'(seq[k]), 32'(rot_exp[k]));

    // Two contenders holding constantly.
    apply('0, 1'b1);
    settle();
    trace.delete();
    npre = 0;
`ifdef RR_TIMEOUT_EN
    repeat (20) apply(4'b0011, 1'b0);
    settle();
    run = 0;
    while (run < trace.size() && trace[run] == 4'b0001) run++;
    check("to_run0", 32'(run), 32'(MAX_HOLD));
    check("to_next", 32'(trace[8]), 32'(4'b0010));
    check("to_back", 32'(trace[16]), 32'(4'b0001));
    check("to_npre", 32'(npre), 32'(2));
`else
    repeat (100) apply(4'b0011, 1'b0);
    settle();
    bad = 0;
    foreach (trace[k]) if (trace[k] != 4'b0001) bad++;
    check("hold_forever", 32'(bad), 32'(0));
    check("hold_npre", 32'(npre), 32'(0));
`endif

    // Sole owner never preempted.
    apply('0, 1'b1);
    settle();
    trace.delete();
    npre = 0;
    repeat (30) apply(4'b0100, 1'b0);
    settle();
    bad = 0;
    foreach (trace[k]) if (trace[k] != 4'b0100) bad++;
    check("sole_hold", 32'(bad), 32'(0));
    check("sole_npre", 32'(npre), 32'(0));

    // Async reset mid-ownership, then ptr restarts at 0.
    apply(4'b0110, 1'b1);
    apply(4'b0110, 1'b0);
    settle();
    check("post_rst_gnt", 32'(GNT), 32'(4'b0010));

    // Randomized traffic with occasional resets.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      r = r ^ (N'($urandom) & N'($urandom));
      apply(r, $urandom_range(0, 99) == 0);
    end
    settle();
    done = 1'b1;
    check("sb_drain", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter sharing one bus/resource among `N` requesters, the fair successor to the existing fixed-priority arbiter. It uses the same `REQ`/`GNT` one-hot convention. A grant is registered and held for as long as its owner keeps `REQ` asserted. Ownership then rotates so every requester is served within `N` grants. An optional hold-timeout forcibly preempts owners that keep the resource too long.

## Interface
- `N`, 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, 8: maximum consecutive grant cycles before forced preemption; legal range ≥ 2; used only with `RR_TIMEOUT_EN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `REQ` input N: request vector; bit i high = requester i wants or holds the resource.
- `GNT` output N: one-hot (or zero) registered grant.
- `GNT_ID` output clog2(N): binary index of the current owner; valid only when `BUSY`=1.
- `BUSY` output 1: high when any `GNT` bit is set.
- `PREEMPT` output 1: one-cycle pulse on the cycle a forced handoff takes effect.

## Operation
- State: `IDLE` (no owner) / `OWNED` (owner = `GNT_ID`); rotating pointer `ptr`; hold counter `hcnt` (width clog2(MAX_HOLD)).
- Arbitration search: scan `REQ` from index `ptr` upward, wrapping from N-1 to 0. The first set bit wins.
- `IDLE`, any `REQ` high: winner granted at next edge; go to `OWNED`; `ptr` ← winner+1 mod N; `hcnt` ← 0.
- `IDLE`, `REQ`=0: stay; `GNT`=0.
- `OWNED`, `REQ[owner]` sampled high: grant held; `hcnt` increments, saturating at MAX_HOLD-1.
- `OWNED`, `REQ[owner]` sampled low: release. At the same edge, re-arbitrate over the remaining `REQ` from `ptr`; zero-cycle handoff.
- If no other requests are pending at release: go to `IDLE`, `GNT`=0.
- A one-cycle `REQ` drop always loses ownership; reasserting makes the requester an ordinary contender.
- Simultaneous new requests while owned: ignored until release or preemption. No grant change mid-ownership.
- Invariants: at most one `GNT` bit set; `GNT` never asserts for a bit whose `REQ` was low at the granting edge.
- Fairness: a continuously asserted request is granted within N-1 ownership periods.

## Timing
- Reset values: `GNT`=0, `GNT_ID`=0, `BUSY`=0, `PREEMPT`=0, `ptr`=0, `hcnt`=0, state `IDLE`. Outputs clear immediately on `reset` assertion, without waiting for a clock edge.
- Reset mid-ownership: grant is dropped asynchronously. After deassertion, requester 0 has highest priority.
- Grant latency: `REQ` high before edge k → `GNT` high after edge k (1 cycle).
- Release latency: `REQ[owner]` low before edge k → `GNT[owner]` low after edge k. The next owner's `GNT` rises on that same edge.
- `GNT`, `GNT_ID`, `BUSY` and `PREEMPT` are all registered outputs; no combinational path from `REQ`.

## Configuration
- `RR_TIMEOUT_EN` defined:
  - When `hcnt` = MAX_HOLD-1 and `REQ[owner]` is still high, the next edge re-arbitrates, excluding the owner.
  - If another requester wins, the grant moves to it and `PREEMPT` pulses for that one cycle.
  - If no other request is pending, the owner keeps the grant, `hcnt` ← 0, and there is no `PREEMPT`.
  - Resulting maximum uninterrupted hold under contention: MAX_HOLD cycles.
- `RR_TIMEOUT_EN` undefined:
  - No hold counter logic; `MAX_HOLD` is ignored.
  - `PREEMPT` is tied to 0.
  - An owner holds the grant indefinitely.

## Test plan
- **Reset:** `reset`=1 with `REQ`=1111 for 3 edges → `GNT`=0000, `BUSY`=0. Deassert → next edge `GNT`=0001, `GNT_ID`=0.
- **Handoff:** from reset, `REQ`=1010 → `GNT`=0010 after 1 edge. Drop `REQ[1]` → next edge `GNT`=1000, `GNT_ID`=3. Drop `REQ[3]` → `GNT`=0000, `BUSY`=0.
- **Rotation:** `REQ`=1111, each owner drops its `REQ` for one cycle after 2 grant cycles and then reasserts → grant order 0001, 0010, 0100, 1000, 0001. The checker verifies every bit is served within 4 ownerships.
- **Timeout (macro on, MAX_HOLD=8):** `REQ`=0011 held constant → `GNT`=0001 for exactly 8 cycles, `PREEMPT` pulse, then `GNT`=0010 for 8 cycles, then 0001 again. Macro off → `GNT` stays 0001 for 100 cycles and `PREEMPT` never rises.
- **Sole owner timeout (macro on):** `REQ`=0100 for 30 cycles → `GNT`=0100 continuously, `PREEMPT` never rises.
- **Async reset mid-op:** `GNT`=0100, assert `reset` between edges → `GNT`=0000 before the next edge. After deassert with `REQ`=0110 → `GNT`=0010 (`ptr` back to 0).
